sd_emmc_axi_write_master: RTL and testbench

SD_EMMC_AXI_WRITE_MASTER -- requirements
Module: sd_emmc_axi_write_master

---
 rtl/sd_emmc_axi_write_master_if.sv | 36 +++
 rtl/sd_emmc_axi_write_master.sv | 205 ++++++++++++++++++++
 tb/tb_sd_emmc_axi_write_master.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_emmc_axi_write_master_if.sv
// AXI4 write-channel bundle between the SD/eMMC DMA write master and the memory fabric.
// The master modport is the DMA engine side, the slave modport is the interconnect side.
interface sd_emmc_axi_write_master_if;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/sd_emmc_axi_write_master.sv
// Single-beat AXI4 write master for the SD/eMMC DMA: one address, one data beat and one
// response per DMA word, with sticky error/timeout flags and a completed-beat counter.
module sd_emmc_axi_write_master #(
    parameter logic [15:0] TIMEOUT = 16'd4095
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] write_addr,
    input  logic        addr_write_valid,
    output logic        addr_write_ready,
    input  logic        data_write_valid,
    input  logic        w_last,
    input  logic [31:0] fifo_dout,
    output logic        next_data_word,
    input  logic        int_rst,
    sd_emmc_axi_write_master_if.master axi,
    output logic [1:0]  resp_err,
    output logic        timeout_err,
    output logic [15:0] beat_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        AW     = 3'd1,
        W_WAIT = 3'd2,
        W      = 3'd3,
        B      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic        addr_write_ready_q, addr_write_ready_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wlast_q, wlast_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        next_data_word_q, next_data_word_d;
    logic [15:0] beat_count_q, beat_count_d;
    logic [1:0]  resp_err_q, resp_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        busy_q, busy_d;

    // Next-state, handshake and status computation.
    always_comb begin
        state_d            = state_q;
        awaddr_d           = awaddr_q;
        awvalid_d          = awvalid_q;
        addr_write_ready_d = 1'b0;
        wdata_d            = wdata_q;
        wlast_d            = wlast_q;
        wvalid_d           = wvalid_q;
        bready_d           = bready_q;
        next_data_word_d   = 1'b0;
        beat_count_d       = beat_count_q;
        resp_err_d         = resp_err_q;
        timeout_err_d      = timeout_err_q;
        wait_cnt_d         = wait_cnt_q;
        busy_d             = busy_q;

        case (state_q)
            IDLE: begin
                // The completion cycle always passes through IDLE before a new address.
                if (addr_write_valid && !next_data_word_q) begin
                    awaddr_d  = write_addr;
                    awvalid_d = 1'b1;
                    state_d   = AW;
                end else begin
                    state_d   = IDLE;
                end
            end
            AW: begin
                if (awvalid_q && axi.m_axi_awready) begin
                    awvalid_d          = 1'b0;
                    addr_write_ready_d = 1'b1;
                    state_d            = W_WAIT;
                end else begin
                    state_d            = AW;
                end
            end
            W_WAIT: begin
                if (data_write_valid) begin
                    wdata_d  = fifo_dout;
                    // awlen is 0, so every beat is the last one whatever the DMA says.
                    wlast_d  = w_last | 1'b1;
                    wvalid_d = 1'b1;
                    state_d  = W;
                end else begin
                    state_d  = W_WAIT;
                end
            end
            W: begin
                if (wvalid_q && axi.m_axi_wready) begin
                    wvalid_d = 1'b0;
                    bready_d = 1'b1;
                    state_d  = B;
                end else begin
                    state_d  = W;
                end
            end
            B: begin
                if (axi.m_axi_bvalid && bready_q) begin
                    bready_d         = 1'b0;
                    next_data_word_d = 1'b1;
                    beat_count_d     = beat_count_q + 16'd1;
                    state_d          = IDLE;
                    if ((axi.m_axi_bresp != 2'b00) && (resp_err_q == 2'b00)) begin
                        resp_err_d = axi.m_axi_bresp;
                    end else begin
                        resp_err_d = resp_err_q;
                    end
                end else begin
                    state_d          = B;
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase

        // Wait counter restarts on every transition and saturates at TIMEOUT.
        if (state_d != state_q) begin
            wait_cnt_d = 16'd0;
        end else if ((state_q != IDLE) && (wait_cnt_q != TIMEOUT)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if ((state_d == state_q) && (state_q != IDLE) && (wait_cnt_d == TIMEOUT)) begin
            timeout_err_d = 1'b1;
        end else begin
            timeout_err_d = timeout_err_d;
        end

        // A clear request beats an error raised in the same cycle.
        if (int_rst) begin
            resp_err_d    = 2'b00;
            timeout_err_d = 1'b0;
        end else begin
            resp_err_d    = resp_err_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q            <= IDLE;
            awaddr_q           <= 32'd0;
            awvalid_q          <= 1'b0;
            addr_write_ready_q <= 1'b0;
            wdata_q            <= 32'd0;
            wlast_q            <= 1'b0;
            wvalid_q           <= 1'b0;
            bready_q           <= 1'b0;
            next_data_word_q   <= 1'b0;
            beat_count_q       <= 16'd0;
            resp_err_q         <= 2'b00;
            timeout_err_q      <= 1'b0;
            wait_cnt_q         <= 16'd0;
            busy_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            awaddr_q           <= awaddr_d;
            awvalid_q          <= awvalid_d;
            addr_write_ready_q <= addr_write_ready_d;
            wdata_q            <= wdata_d;
            wlast_q            <= wlast_d;
            wvalid_q           <= wvalid_d;
            bready_q           <= bready_d;
            next_data_word_q   <= next_data_word_d;
            beat_count_q       <= beat_count_d;
            resp_err_q         <= resp_err_d;
            timeout_err_q      <= timeout_err_d;
            wait_cnt_q         <= wait_cnt_d;
            busy_q             <= busy_d;
        end
    end

    assign axi.m_axi_awaddr  = awaddr_q;
    assign axi.m_axi_awlen   = 8'd0;
    assign axi.m_axi_awsize  = 3'b010;
    assign axi.m_axi_awburst = 2'b01;
    assign axi.m_axi_awvalid = awvalid_q;
    assign axi.m_axi_wdata   = wdata_q;
    assign axi.m_axi_wstrb   = 4'hF;
    assign axi.m_axi_wlast   = wlast_q;
    assign axi.m_axi_wvalid  = wvalid_q;
    assign axi.m_axi_bready  = bready_q;

    assign addr_write_ready = addr_write_ready_q;
    assign next_data_word   = next_data_word_q;
    assign resp_err         = resp_err_q;
    assign timeout_err      = timeout_err_q;
    assign beat_count       = beat_count_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_sd_emmc_axi_write_master.sv
// Directed self-checking bench for sd_emmc_axi_write_master (TIMEOUT overridden to 8).
module tb_sd_emmc_axi_write_master;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] write_addr = 32'd0;
    logic        addr_write_valid = 1'b0;
    logic        addr_write_ready;
    logic        data_write_valid = 1'b0;
    logic        w_last = 1'b0;
    logic [31:0] fifo_dout = 32'd0;
    logic        next_data_word;
    logic        int_rst = 1'b0;
    logic [1:0]  resp_err;
    logic        timeout_err;
    logic [15:0] beat_count;
    logic        busy;

    int checks    = 0;
    int failures  = 0;
    int exp_beats = 0;

    sd_emmc_axi_write_master_if axi ();

    sd_emmc_axi_write_master #(.TIMEOUT(16'd8)) dut (
        .clock            (clock),
        .reset            (reset),
        .write_addr       (write_addr),
        .addr_write_valid (addr_write_valid),
        .addr_write_ready (addr_write_ready),
        .data_write_valid (data_write_valid),
        .w_last           (w_last),
        .fifo_dout        (fifo_dout),
        .next_data_word   (next_data_word),
        .int_rst          (int_rst),
        .axi              (axi),
        .resp_err         (resp_err),
        .timeout_err      (timeout_err),
        .beat_count       (beat_count),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pattern(input int i);
        logic [31:0] v;
        v = 32'(i);
        return v ^ 32'hA5A5_0000;
    endfunction

    // Launch one beat and follow it until two cycles after its completion pulse.
    task automatic do_beat(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] br,
                           output int lat, output logic [31:0] seen_aw, output logic [31:0] seen_w,
                           output logic seen_last, output int ndw_cnt);
        lat = 0; ndw_cnt = 0; seen_aw = 32'd0; seen_w = 32'd0; seen_last = 1'b0;
        write_addr = addr; fifo_dout = data; axi.m_axi_bresp = br;
        addr_write_valid = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (axi.m_axi_awvalid) seen_aw = axi.m_axi_awaddr;
            if (axi.m_axi_wvalid) begin seen_w = axi.m_axi_wdata; seen_last = axi.m_axi_wlast; end
            if (addr_write_ready) addr_write_valid = 1'b0;
            if (next_data_word) begin ndw_cnt++; if (lat == 0) lat = i; end
            if (lat != 0 && i >= lat + 2) break;
        end
        addr_write_valid = 1'b0;
        exp_beats++;
    endtask

    task automatic run_to_b(input logic [31:0] addr);
        logic ok;
        ok = 1'b0;
        write_addr = addr;
        addr_write_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (addr_write_ready) addr_write_valid = 1'b0;
            if (axi.m_axi_bready) begin ok = 1'b1; break; end
        end
        addr_write_valid = 1'b0;
        check_eq("reach_b", 32'(ok), 32'd1);
    endtask

    task automatic count_ndw(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (addr_write_ready) addr_write_valid = 1'b0;
            if (next_data_word) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, naw, nndw, nawr, nw, bad_addr, bad_data, overlap;
        logic [31:0] aw, wd, last_aw;
        logic wl, prev_awv, prev_wv;

        axi.m_axi_awready = 1'b1;
        axi.m_axi_wready  = 1'b1;
        axi.m_axi_bvalid  = 1'b1;
        axi.m_axi_bresp   = 2'b00;

        // Reset state
        reset = 1'b0;
        repeat (3) step();
        check_eq("rst_awvalid", 32'(axi.m_axi_awvalid), 32'd0);
        check_eq("rst_wvalid", 32'(axi.m_axi_wvalid), 32'd0);
        check_eq("rst_bready", 32'(axi.m_axi_bready), 32'd0);
        check_eq("rst_awr", 32'(addr_write_ready), 32'd0);
        check_eq("rst_ndw", 32'(next_data_word), 32'd0);
        check_eq("rst_awaddr", axi.m_axi_awaddr, 32'd0);
        check_eq("rst_wdata", axi.m_axi_wdata, 32'd0);
        check_eq("rst_wlast", 32'(axi.m_axi_wlast), 32'd0);
        check_eq("rst_beats", 32'(beat_count), 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_timeout", 32'(timeout_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_awlen", 32'(axi.m_axi_awlen), 32'd0);
        check_eq("rst_awsize", 32'(axi.m_axi_awsize), 32'd2);
        check_eq("rst_awburst", 32'(axi.m_axi_awburst), 32'd1);
        check_eq("rst_wstrb", 32'(axi.m_axi_wstrb), 32'hF);
        reset = 1'b1;
        step();

        // Single beat, all readies high, w_last input low (wlast still forced)
        data_write_valid = 1'b1;
        w_last = 1'b0;
        do_beat(32'h1000_0000, 32'hDEADBEEF, 2'b00, lat, aw, wd, wl, n);
        check_eq("single_latency", 32'(lat), 32'd5);
        check_eq("single_awaddr", aw, 32'h1000_0000);
        check_eq("single_wdata", wd, 32'hDEADBEEF);
        check_eq("single_wlast", 32'(wl), 32'd1);
        check_eq("single_wstrb", 32'(axi.m_axi_wstrb), 32'hF);
        check_eq("single_ndw_count", 32'(n), 32'd1);
        check_eq("single_beats", 32'(beat_count), 32'd1);
        check_eq("single_busy_after", 32'(busy), 32'd0);

        // awready delayed 10 cycles
        axi.m_axi_awready = 1'b0;
        write_addr = 32'h2000_0040;
        addr_write_valid = 1'b1;
        step();
        write_addr = 32'h2000_0080;
        bad_addr = 0; nawr = 0;
        for (int i = 0; i < 10; i++) begin
            if (!axi.m_axi_awvalid || axi.m_axi_awaddr != 32'h2000_0040) bad_addr++;
            if (addr_write_ready) nawr++;
            if (i < 9) step();
        end
        check_eq("awdelay_stable", 32'(bad_addr), 32'd0);
        check_eq("awdelay_no_early_awr", 32'(nawr), 32'd0);
        check_eq("awdelay_busy", 32'(busy), 32'd1);
        axi.m_axi_awready = 1'b1;
        step();
        check_eq("awdelay_awr_pulse", 32'(addr_write_ready), 32'd1);
        check_eq("awdelay_awvalid_clr", 32'(axi.m_axi_awvalid), 32'd0);
        addr_write_valid = 1'b0;
        step();
        check_eq("awdelay_awr_once", 32'(addr_write_ready), 32'd0);
        count_ndw(20, n);
        exp_beats++;
        check_eq("awdelay_ndw", 32'(n), 32'd1);
        check_eq("awdelay_timeout_sticky", 32'(timeout_err), 32'd1);
        int_rst = 1'b1; step(); int_rst = 1'b0;
        check_eq("awdelay_timeout_cleared", 32'(timeout_err), 32'd0);

        // Sticky first error response
        do_beat(32'h3000_0000, 32'h1111_2222, 2'b10, lat, aw, wd, wl, n);
        check_eq("err1_resp", 32'(resp_err), 32'd2);
        check_eq("err1_completes", 32'(n), 32'd1);
        do_beat(32'h3000_0004, 32'h3333_4444, 2'b11, lat, aw, wd, wl, n);
        check_eq("err2_keeps_first", 32'(resp_err), 32'd2);
        int_rst = 1'b1; step(); int_rst = 1'b0;
        check_eq("err_cleared", 32'(resp_err), 32'd0);

        // Clear coinciding with an error response
        axi.m_axi_bvalid = 1'b0;
        run_to_b(32'h3000_0008);
        axi.m_axi_bresp = 2'b01;
        axi.m_axi_bvalid = 1'b1;
        int_rst = 1'b1;
        step();
        int_rst = 1'b0;
        exp_beats++;
        check_eq("clr_win_ndw", 32'(next_data_word), 32'd1);
        check_eq("clr_win_resp", 32'(resp_err), 32'd0);
        step();
        check_eq("clr_win_resp_later", 32'(resp_err), 32'd0);
        axi.m_axi_bresp = 2'b00;

        // Timeout in W with wready low for 20 cycles
        axi.m_axi_wready = 1'b0;
        write_addr = 32'h4000_0000;
        addr_write_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (addr_write_ready) addr_write_valid = 1'b0;
            if (axi.m_axi_wvalid) begin n = 1; break; end
        end
        check_eq("to_reach_w", 32'(n), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 7) check_eq("to_not_yet", 32'(timeout_err), 32'd0);
            if (k == 8) check_eq("to_at_8", 32'(timeout_err), 32'd1);
        end
        check_eq("to_still_w", 32'(axi.m_axi_wvalid), 32'd1);
        check_eq("to_no_bready", 32'(axi.m_axi_bready), 32'd0);
        axi.m_axi_wready = 1'b1;
        count_ndw(10, n);
        exp_beats++;
        check_eq("to_beat_done", 32'(n), 32'd1);
        check_eq("to_sticky", 32'(timeout_err), 32'd1);
        check_eq("to_beats", 32'(beat_count), 32'(exp_beats));
        int_rst = 1'b1; step(); int_rst = 1'b0;

        // 128 back-to-back beats, DMA address +4 per accepted address
        write_addr = 32'd0;
        fifo_dout = pattern(0);
        addr_write_valid = 1'b1;
        naw = 0; nndw = 0; nawr = 0; nw = 0; bad_addr = 0; bad_data = 0; overlap = 0;
        prev_awv = 1'b0; prev_wv = 1'b0; last_aw = 32'hFFFF_FFFF;
        for (int i = 0; i < 3000 && nndw < 128; i++) begin
            step();
            if (axi.m_axi_awvalid && !prev_awv) begin
                if (axi.m_axi_awaddr != 32'(naw * 4)) bad_addr++;
                last_aw = axi.m_axi_awaddr;
                naw++;
            end
            prev_awv = axi.m_axi_awvalid;
            if (axi.m_axi_wvalid && !prev_wv) begin
                if (axi.m_axi_wdata != pattern(nw)) bad_data++;
                nw++;
            end
            prev_wv = axi.m_axi_wvalid;
            if (next_data_word) begin
                if (axi.m_axi_awvalid) overlap++;
                nndw++;
                fifo_dout = pattern(nndw);
            end
            if (addr_write_ready) begin
                nawr++;
                write_addr = write_addr + 32'd4;
                if (nawr == 128) addr_write_valid = 1'b0;
            end
        end
        addr_write_valid = 1'b0;
        count_ndw(8, n);
        exp_beats += 128;
        check_eq("b2b_aw_count", 32'(naw), 32'd128);
        check_eq("b2b_ndw_count", 32'(nndw), 32'd128);
        check_eq("b2b_extra_ndw", 32'(n), 32'd0);
        check_eq("b2b_addr_seq", 32'(bad_addr), 32'd0);
        check_eq("b2b_data_seq", 32'(bad_data), 32'd0);
        check_eq("b2b_no_aw_on_ndw", 32'(overlap), 32'd0);
        check_eq("b2b_last_awaddr", last_aw, 32'h0000_01FC);
        check_eq("b2b_beats", 32'(beat_count), 32'(exp_beats));

        // Reset asserted while waiting in B
        axi.m_axi_bvalid = 1'b0;
        run_to_b(32'h5000_0000);
        step();
        reset = 1'b0;
        step();
        check_eq("rstb_busy", 32'(busy), 32'd0);
        check_eq("rstb_bready", 32'(axi.m_axi_bready), 32'd0);
        check_eq("rstb_ndw", 32'(next_data_word), 32'd0);
        check_eq("rstb_beats", 32'(beat_count), 32'd0);
        axi.m_axi_bvalid = 1'b1;
        step();
        check_eq("rstb_ndw_hold", 32'(next_data_word), 32'd0);
        reset = 1'b1;
        step();
        check_eq("rstb_ndw_after", 32'(next_data_word), 32'd0);
        check_eq("rstb_idle", 32'(busy), 32'd0);
        check_eq("const_awsize", 32'(axi.m_axi_awsize), 32'd2);
        check_eq("const_awburst", 32'(axi.m_axi_awburst), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
